// File: rtl/regbank_sb_pkg.sv
// Shared types and constants for the register bank.
// Write-source encodings and CPU-level default sizes.
package regbank_sb_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_NREG   = 16;

  typedef logic [2:0] src_t;

  localparam src_t SRC_IN_A  = 3'd0;
  localparam src_t SRC_IN_B  = 3'd1;
  localparam src_t SRC_CONST = 3'd2;
  localparam src_t SRC_ALU   = 3'd3;
  localparam src_t SRC_MOV   = 3'd4;

endpackage

// File: rtl/regbank_scoreboard.sv
// Per-register pending flags for in-flight ALU results.
// A set beats a clear on the same address; stall is combinational.
module regbank_scoreboard #(
  parameter int NREG   = 16,
  parameter int BYPASS = 1,
  parameter int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              set,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [NREG-1:0]   pending,
  output logic              stall
);

  localparam logic [NREG-1:0] ONE = {{(NREG-1){1'b0}}, 1'b1};

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] eff;

  // Decode set/clear into one-hot masks.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set) set_vec = ONE << set_addr;
    if (clr) clr_vec = ONE << clr_addr;
  end

  // Pending flags: clear first, then set so the set wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pending <= '0;
    else       pending <= (pending & ~clr_vec) | set_vec;
  end

  // Hazard detect; a retiring writeback is forwarded, so hide it.
  always_comb begin
    eff = pending;
    if (BYPASS != 0) eff = pending & ~clr_vec;
    stall = 1'b0;
    if (!reset)
      stall = eff[rd_addr_a] | eff[rd_addr_b]
            | (set & eff[set_addr]);
  end

endmodule

// File: rtl/regbank_sb.sv
// Register bank with write-source mux, two read ports,
// optional write-through bypass and ALU pending scoreboard.
module regbank_sb
  import regbank_sb_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int NREG    = DEF_NREG,
  parameter int OUT_REG = 0,
  parameter int BYPASS  = 1,
  localparam int ADDR_W = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  input  logic [DATA_W-1:0] cu_const,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        src_sel,
  input  logic [ADDR_W-1:0] mov_addr,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic              issue,
  input  logic [ADDR_W-1:0] issue_addr,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic [DATA_W-1:0] out,
  output logic              stall,
  output logic              wr_conflict,
  output logic [NREG-1:0]   pending
);

  logic [DATA_W-1:0] regs [NREG];
  logic [DATA_W-1:0] wd;
  logic              is_alu;
  logic              blocked;
  logic              commit;
  logic              fwd;

  assign is_alu  = (src_sel == SRC_ALU);
  assign blocked = we & ~is_alu & pending[wr_addr];
  assign commit  = we & ~blocked;
  assign fwd     = (BYPASS != 0) & commit & ~reset;

  // Write source select; moves read the stored value.
  always_comb begin
    wd = regs[mov_addr];
    case (src_sel)
      SRC_IN_A:  wd = in_a;
      SRC_IN_B:  wd = in_b;
      SRC_CONST: wd = cu_const;
      SRC_ALU:   wd = alu_out;
      default:   wd = regs[mov_addr];
    endcase
  end

  // Register array update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (commit) begin
      regs[wr_addr] <= wd;
    end
  end

  // One-cycle pulse when a non-ALU write hits a pending register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_conflict <= 1'b0;
    else       wr_conflict <= blocked;
  end

  // Read ports with optional write-through forwarding.
  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    if (fwd && rd_addr_a == wr_addr) rd_data_a = wd;
    if (fwd && rd_addr_b == wr_addr) rd_data_b = wd;
    if (reset) begin
      rd_data_a = '0;
      rd_data_b = '0;
    end
  end

  assign out = reset ? '0 : regs[OUT_REG];

  regbank_scoreboard #(
    .NREG   (NREG),
    .BYPASS (BYPASS),
    .ADDR_W (ADDR_W)
  ) u_sb (
    .clk       (clk),
    .reset     (reset),
    .set       (issue),
    .set_addr  (issue_addr),
    .clr       (we & is_alu),
    .clr_addr  (wr_addr),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .pending   (pending),
    .stall     (stall)
  );

endmodule
